pipearch_dma_read_strided: RTL
==============================

Name: pipearch_dma_read_strided

Overview:
- Parametrised AXI4 read DMA engine that replaces the fixed single-shot read path.
- Queues line-granular read commands, each with an optional 2-D stride (repeat count plus segment stride), and generates its own AXI bursts.
- Splits bursts at 4 KB boundaries and limits outstanding requests by buffer credits, so R data is never back-pressured.
- Delivers lines in order on a valid/ready stream with a per-command last flag; sits between the AXI gmem port and the accelerator datapath.

Parameters:
ADDR_W, 64, AXI byte-address width
DATA_W, 512, line width in bits; power of two, 32..1024; LINE_BYTES = DATA_W/8
MAX_BURST, 64, maximum AXI beats per burst; power of two, at most 256
MAX_OUTSTANDING, 4, maximum AR bursts in flight
LOG2_BUF_DEPTH, 9, log2 of read data buffer depth in lines; BUF_DEPTH must be at least MAX_BURST
LOG2_CMD_DEPTH, 3, log2 of command FIFO depth

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_addr  in  ADDR_W  start byte address; must be LINE_BYTES aligned
cmd_lines  in  32  lines per segment
cmd_stride  in  32  segment-to-segment stride, in lines
cmd_repeat  in  16  number of segments
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_araddr  out  ADDR_W  burst byte address
m_axi_arlen  out  8  beats minus 1
m_axi_arsize  out  3  log2(LINE_BYTES), constant
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axi_rdata  in  DATA_W  R data
m_axi_rresp  in  2  R response
m_axi_rlast  in  1  R last
out_valid  out  1  line available
out_ready  in  1  consumer accepts line
out_data  out  DATA_W  line data
out_last  out  1  final line of the current command
idle  out  1  FSM in IDLE and command FIFO empty
done  out  1  one-cycle pulse per completed command
error  out  1  sticky: a non-OKAY rresp was seen during the current command

Behaviour:
- Reset values: m_axi_arvalid=0, out_valid=0, out_last=0, done=0, error=0, idle=1.
- On reset (including mid-operation): command FIFO, data buffer and all counters cleared; in-flight AXI beats are not drained.
- Command FIFO accepts when cmd_valid && cmd_ready; cmd_ready = !full.
- FSM states:
  - IDLE: pop a command when the FIFO is non-empty, then go to SETUP.
  - SETUP (1 cycle): latch fields, clear error, seg=0, seg_off=0, compute total = lines*repeat. If total==0, go to DONE.
  - ISSUE: generate bursts; go to DRAIN after the final AR handshake.
  - DRAIN: wait until consumed == total.
  - DONE: pulse done for 1 cycle, return to IDLE.
- Burst address: cmd_addr + (seg*stride + seg_off)*LINE_BYTES, computed in ADDR_W bits and wrapping modulo 2^ADDR_W.
- Burst length: min(lines - seg_off, MAX_BURST, (4096 - addr[11:0])/LINE_BYTES); never crosses a 4 KB boundary.
- Issue condition: all of
  - outstanding < MAX_OUTSTANDING;
  - BUF_DEPTH - (requested - consumed) >= burst length.
- Once asserted, m_axi_arvalid and its address/length hold stable until arready.
- On AR handshake:
  - requested += beats and outstanding++;
  - seg_off += beats; when seg_off == lines, seg_off = 0 and seg++.
- Outstanding is decremented on an R beat with rlast.
- m_axi_rready = 1 whenever the FSM is in ISSUE or DRAIN; buffer space is reserved by credits, so overflow is impossible.
- Beats are written into the buffer in arrival order; a single AXI ID is used, so responses arrive in order.
- Non-OKAY rresp sets error, and the data is still forwarded.
- Output stream:
  - out_valid = buffer not empty; out_data is held stable while out_valid && !out_ready.
  - Data may be registered, with first-line latency at most 2 cycles after the R beat.
  - out_last = 1 on line index total-1.
  - Each accepted line increments consumed.
- Same-cycle cases:
  - AR handshake and R beat in the same cycle both update their counters.
  - Issue credit is evaluated on the registered (requested - consumed).
- Counters requested, consumed and total are 48 bits wide, covering (2^32-1)*(2^16-1) lines.
- done asserts the cycle after the last out handshake; the next command may begin SETUP in the cycle following done.

Test Plan:
- 512-bit lines, addr 0x1000, lines=8, repeat=1, arready and out_ready held 1 -> exactly one AR (araddr 0x1000, arlen 7); 8 out beats, out_last on the 8th; one done pulse.
- addr 0x0FC0, lines=4 -> AR1 (0x0FC0, arlen 0), AR2 (0x1000, arlen 2); no burst crosses 4 KB.
- Strided: addr 0, lines=2, stride=16, repeat=3 -> ARs at 0x000, 0x400, 0x800, each arlen 1; 6 lines out, out_last on the 6th.
- BUF_DEPTH=64, MAX_BURST=64, lines=256, out_ready=0 -> one AR only; rready stays 1 and no beat is lost. Raise out_ready -> the remaining 3 ARs issue and all 256 lines are delivered in address order.
- Zero-length: lines=0 -> done 2 cycles after the command is popped; no AR, no out_valid.
- rresp=2'b10 on beat 3 of 8 -> error=1 through done, data still delivered. Next command clears error in SETUP. Reset asserted mid-burst -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/pipearch_dma_read_strided.sv
// rtl/pipearch_dma_read_strided.sv - AXI4 read DMA with 2-D strided commands, 4 KB burst split and credit-limited issue
module pipearch_dma_read_strided #(
   parameter int ADDR_W          = 64,
   parameter int DATA_W          = 512,
   parameter int MAX_BURST       = 64,
   parameter int MAX_OUTSTANDING = 4,
   parameter int LOG2_BUF_DEPTH  = 9,
   parameter int LOG2_CMD_DEPTH  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_lines,
   input  logic [31:0]       cmd_stride,
   input  logic [15:0]       cmd_repeat,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              idle,
   output logic              done,
   output logic              error
);
   localparam int LINE_BYTES = DATA_W / 8;
   localparam int LB_SHIFT   = $clog2(LINE_BYTES);
   localparam int BUF_DEPTH  = 1 << LOG2_BUF_DEPTH;
   localparam int CMD_DEPTH  = 1 << LOG2_CMD_DEPTH;
   localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
   localparam int CMD_W      = ADDR_W + 32 + 32 + 16;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [CMD_W-1:0]        cmd_mem [CMD_DEPTH];
   logic [DATA_W-1:0]       buf_mem [BUF_DEPTH];
   logic [LOG2_CMD_DEPTH:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
   logic [LOG2_BUF_DEPTH:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
   logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d, araddr_q, araddr_d;
   logic [31:0]             cur_lines_q, cur_lines_d, cur_stride_q, cur_stride_d;
   logic [15:0]             cur_repeat_q, cur_repeat_d, seg_q, seg_d;
   logic [31:0]             seg_off_q, seg_off_d;
   logic [47:0]             total_q, total_d, requested_q, requested_d, consumed_q, consumed_d;
   logic [OUT_W-1:0]        outstanding_q, outstanding_d;
   logic [7:0]              arlen_q, arlen_d;
   logic                    arvalid_q, arvalid_d, done_q, done_d, error_q, error_d;

   logic                    cmd_full, cmd_empty, cmd_push, cmd_pop;
   logic [CMD_W-1:0]        cmd_head;
   logic                    r_beat, out_hs, ar_hs, seg_wrap, can_issue;
   logic [47:0]             line_idx, credit_free, product;
   logic [ADDR_W-1:0]       burst_addr;
   logic [12:0]             page_room;
   logic [31:0]             seg_rem, burst_len, ar_beats, seg_off_adv;

   assign cmd_empty = (cmd_wr_q == cmd_rd_q);
   assign cmd_full  = (cmd_wr_q[LOG2_CMD_DEPTH] != cmd_rd_q[LOG2_CMD_DEPTH]) &&
                      (cmd_wr_q[LOG2_CMD_DEPTH-1:0] == cmd_rd_q[LOG2_CMD_DEPTH-1:0]);
   assign cmd_ready = !cmd_full;
   assign cmd_push  = cmd_valid && !cmd_full;
   assign cmd_head  = cmd_mem[cmd_rd_q[LOG2_CMD_DEPTH-1:0]];

   assign m_axi_rready  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign r_beat        = m_axi_rvalid && m_axi_rready;
   assign out_valid     = (buf_wr_q != buf_rd_q);
   assign out_data      = buf_mem[buf_rd_q[LOG2_BUF_DEPTH-1:0]];
   assign out_hs        = out_valid && out_ready;
   assign out_last      = out_valid && (consumed_q == total_q - 48'd1);
   assign idle          = (state_q == S_IDLE) && cmd_empty;
   assign done          = done_q;
   assign error         = error_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = 3'(LB_SHIFT);
   assign ar_hs         = arvalid_q && m_axi_arready;
   assign ar_beats      = 32'(arlen_q) + 32'd1;
   assign seg_off_adv   = seg_off_q + ar_beats;
   assign seg_wrap      = (seg_off_adv == cur_lines_q);
   assign product       = 48'(cur_lines_q) * 48'(cur_repeat_q);

   // Next burst: clipped by segment remainder, MAX_BURST and the 4 KB page end
   always_comb begin
      line_idx    = 48'(seg_q) * 48'(cur_stride_q) + 48'(seg_off_q);
      burst_addr  = cur_addr_q + (ADDR_W'(line_idx) << LB_SHIFT);
      page_room   = (13'd4096 - {1'b0, burst_addr[11:0]}) >> LB_SHIFT;
      seg_rem     = cur_lines_q - seg_off_q;
      burst_len   = 32'(MAX_BURST);
      if (seg_rem < burst_len) burst_len = seg_rem;
      if (32'(page_room) < burst_len) burst_len = 32'(page_room);
      credit_free = 48'(BUF_DEPTH) - (requested_q - consumed_q);
      can_issue   = (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && (credit_free >= 48'(burst_len));
   end

   always_comb begin
      state_d       = state_q;
      cmd_pop       = 1'b0;
      cur_addr_d    = cur_addr_q;
      cur_lines_d   = cur_lines_q;
      cur_stride_d  = cur_stride_q;
      cur_repeat_d  = cur_repeat_q;
      seg_d         = seg_q;
      seg_off_d     = seg_off_q;
      total_d       = total_q;
      requested_d   = requested_q;
      consumed_d    = consumed_q + (out_hs ? 48'd1 : 48'd0);
      outstanding_d = outstanding_q;
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      arlen_d       = arlen_q;
      done_d        = 1'b0;
      error_d       = error_q || (r_beat && (m_axi_rresp != 2'b00));
      if (ar_hs) begin
         requested_d   = requested_q + 48'(ar_beats);
         outstanding_d = outstanding_d + OUT_W'(1);
      end
      if (r_beat && m_axi_rlast) outstanding_d = outstanding_d - OUT_W'(1);
      case (state_q)
         S_IDLE, S_DONE: begin
            // DONE pops directly so a queued command reaches SETUP right after the done pulse
            state_d = S_IDLE;
            if (!cmd_empty) begin
               cmd_pop      = 1'b1;
               cur_addr_d   = cmd_head[CMD_W-1 -: ADDR_W];
               cur_lines_d  = cmd_head[79:48];
               cur_stride_d = cmd_head[47:16];
               cur_repeat_d = cmd_head[15:0];
               state_d      = S_SETUP;
            end
         end
         S_SETUP: begin
            total_d     = product;
            error_d     = 1'b0;
            seg_d       = 16'd0;
            seg_off_d   = 32'd0;
            requested_d = 48'd0;
            consumed_d  = 48'd0;
            if (product == 48'd0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!arvalid_q && can_issue) begin
               arvalid_d = 1'b1;
               araddr_d  = burst_addr;
               arlen_d   = 8'(burst_len - 32'd1);
            end
            if (ar_hs) begin
               arvalid_d = 1'b0;
               seg_off_d = seg_wrap ? 32'd0 : seg_off_adv;
               seg_d     = seg_wrap ? seg_q + 16'd1 : seg_q;
               if (seg_wrap && (seg_q + 16'd1 == cur_repeat_q)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (consumed_d == total_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      cmd_wr_d = cmd_wr_q + (cmd_push ? 1'b1 : 1'b0);
      cmd_rd_d = cmd_rd_q + (cmd_pop ? 1'b1 : 1'b0);
      buf_wr_d = buf_wr_q + (r_beat ? 1'b1 : 1'b0);
      buf_rd_d = buf_rd_q + (out_hs ? 1'b1 : 1'b0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cmd_wr_q      <= '0;
         cmd_rd_q      <= '0;
         buf_wr_q      <= '0;
         buf_rd_q      <= '0;
         cur_addr_q    <= '0;
         cur_lines_q   <= '0;
         cur_stride_q  <= '0;
         cur_repeat_q  <= '0;
         seg_q         <= '0;
         seg_off_q     <= '0;
         total_q       <= '0;
         requested_q   <= '0;
         consumed_q    <= '0;
         outstanding_q <= '0;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         arlen_q       <= '0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_wr_q      <= cmd_wr_d;
         cmd_rd_q      <= cmd_rd_d;
         buf_wr_q      <= buf_wr_d;
         buf_rd_q      <= buf_rd_d;
         cur_addr_q    <= cur_addr_d;
         cur_lines_q   <= cur_lines_d;
         cur_stride_q  <= cur_stride_d;
         cur_repeat_q  <= cur_repeat_d;
         seg_q         <= seg_d;
         seg_off_q     <= seg_off_d;
         total_q       <= total_d;
         requested_q   <= requested_d;
         consumed_q    <= consumed_d;
         outstanding_q <= outstanding_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         arlen_q       <= arlen_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cmd_wr_q[LOG2_CMD_DEPTH-1:0]] <= {cmd_addr, cmd_lines, cmd_stride, cmd_repeat};
      if (r_beat) buf_mem[buf_wr_q[LOG2_BUF_DEPTH-1:0]] <= m_axi_rdata;
   end
endmodule
